neural_sig_unit: RTL and testbench

//  Hardware activation engine behind the Nios sigmoid PIOs of neural_soc.
//  - Consumes operands/commands from to_sig_hw_port, to_isig_hw_port and to_hw_sig.
//  - Returns sigma(x) or sigma'(x) on to_sig_sw_port / to_isig_sw_port.
//  - Status goes back on to_sw_sig via a four-phase handshake.
//  - Q16.16 piecewise-linear (PLAN) sigmoid; shift/add only, one multiplier for the derivative.

---
 rtl/neural_sig_unit.sv | 160 ++++++++++++++++
 tb/tb_neural_sig_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neural_sig_unit.sv
// Piecewise-linear (PLAN) Q-format sigmoid / sigmoid-derivative engine with a four-phase status handshake.
// Optional NEURAL_SIG_PERF_EN adds a 16-bit completed-operation counter on port op_count.
module neural_sig_unit #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [WIDTH-1:0] sig_in,
   input  logic [WIDTH-1:0] isig_in,
   input  logic [1:0]       hw_sig,
   output logic [WIDTH-1:0] sig_out,
   output logic [WIDTH-1:0] isig_out,
   output logic [1:0]       sw_sig
`ifdef NEURAL_SIG_PERF_EN
   ,
   output logic [15:0]      op_count
`endif
);

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1)  << FRAC_BITS;
   localparam logic [WIDTH-1:0] FIVE    = WIDTH'(5)  << FRAC_BITS;
   localparam logic [WIDTH-1:0] BRK_HI  = WIDTH'(19) << (FRAC_BITS - 3);
   localparam logic [WIDTH-1:0] OFS_HI  = WIDTH'(27) << (FRAC_BITS - 5);
   localparam logic [WIDTH-1:0] OFS_MID = WIDTH'(5)  << (FRAC_BITS - 3);
   localparam logic [WIDTH-1:0] OFS_LO  = WIDTH'(1)  << (FRAC_BITS - 1);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;
   localparam logic [1:0] ST_ERR  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_ABS, S_SEG, S_SYM, S_MUL, S_DONE, S_ERR} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] x_q, x_nxt;
   logic             op_q, op_nxt;
   logic [WIDTH-1:0] a_q, a_nxt;
   logic [WIDTH-1:0] y_q, y_nxt;
   logic [WIDTH-1:0] sig_nxt, isig_nxt;
   logic [1:0]       sw_nxt;
   logic             done_entry;
   logic [WIDTH-1:0] y_sym;
   logic [WIDTH-1:0] one_minus_y;

   // Odd symmetry: sigma(-x) = 1 - sigma(|x|); sign comes from the latched operand.
   assign y_sym       = x_q[WIDTH-1] ? (ONE - y_q) : y_q;
   assign one_minus_y = ONE - y_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state    <= S_IDLE;
         x_q      <= '0;
         op_q     <= 1'b0;
         a_q      <= '0;
         y_q      <= '0;
         sig_out  <= '0;
         isig_out <= '0;
         sw_sig   <= ST_IDLE;
      end else begin
         state    <= state_nxt;
         x_q      <= x_nxt;
         op_q     <= op_nxt;
         a_q      <= a_nxt;
         y_q      <= y_nxt;
         sig_out  <= sig_nxt;
         isig_out <= isig_nxt;
         sw_sig   <= sw_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      x_nxt      = x_q;
      op_nxt     = op_q;
      a_nxt      = a_q;
      y_nxt      = y_q;
      sig_nxt    = sig_out;
      isig_nxt   = isig_out;
      sw_nxt     = sw_sig;
      done_entry = 1'b0;
      case (state)
         S_IDLE: begin
            if (hw_sig == 2'b01 || hw_sig == 2'b10) begin
               x_nxt     = hw_sig[1] ? isig_in : sig_in;
               op_nxt    = hw_sig[1];
               sw_nxt    = ST_BUSY;
               state_nxt = S_ABS;
            end else if (hw_sig == 2'b11) begin
               sw_nxt    = ST_ERR;
               state_nxt = S_ERR;
            end
         end
         S_ABS: begin
            // Most-negative operand has no positive twin; clamp it.
            if (x_q == MIN_NEG)
               a_nxt = MAX_POS;
            else if (x_q[WIDTH-1])
               a_nxt = WIDTH'(0) - x_q;
            else
               a_nxt = x_q;
            state_nxt = S_SEG;
         end
         S_SEG: begin
            if (a_q >= FIVE)
               y_nxt = ONE;
            else if (a_q >= BRK_HI)
               y_nxt = (a_q >> 5) + OFS_HI;
            else if (a_q >= ONE)
               y_nxt = (a_q >> 3) + OFS_MID;
            else
               y_nxt = (a_q >> 2) + OFS_LO;
            state_nxt = S_SYM;
         end
         S_SYM: begin
            if (op_q) begin
               y_nxt     = y_sym;
               state_nxt = S_MUL;
            end else begin
               sig_nxt    = y_sym;
               sw_nxt     = ST_DONE;
               state_nxt  = S_DONE;
               done_entry = 1'b1;
            end
         end
         S_MUL: begin
            // y and 1-y both lie in [0, ONE], so the unsigned product never overflows the result.
            isig_nxt   = WIDTH'(({{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, one_minus_y}) >> FRAC_BITS);
            sw_nxt     = ST_DONE;
            state_nxt  = S_DONE;
            done_entry = 1'b1;
         end
         S_DONE, S_ERR: begin
            if (hw_sig == 2'b00) begin
               sw_nxt    = ST_IDLE;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            sw_nxt    = ST_IDLE;
            state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef NEURAL_SIG_PERF_EN
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         op_count <= '0;
      else if (done_entry)
         op_count <= op_count + 16'd1;
   end
`else
   logic unused_done_entry;
   assign unused_done_entry = done_entry;
`endif

endmodule

// File: tb/tb_neural_sig_unit.sv
// Directed table-driven bench for neural_sig_unit: sigmoid/derivative values, latency, handshake, error and reset.
module tb_neural_sig_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] sig_in, isig_in;
   logic [1:0]  hw_sig;
   logic [31:0] sig_out, isig_out;
   logic [1:0]  sw_sig;
`ifdef NEURAL_SIG_PERF_EN
   logic [15:0] op_count;
`endif

   always #5 clk = ~clk;

   neural_sig_unit #(.WIDTH(32), .FRAC_BITS(16)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .sig_in        (sig_in),
      .isig_in       (isig_in),
      .hw_sig        (hw_sig),
      .sig_out       (sig_out),
      .isig_out      (isig_out),
      .sw_sig        (sw_sig)
`ifdef NEURAL_SIG_PERF_EN
      ,
      .op_count      (op_count)
`endif
   );

   typedef struct {
      logic        der;
      logic [31:0] x;
      logic [31:0] res;
   } vec_t;

   vec_t        vecs[15];
   int          total  = 0;
   int          passed = 0;
   int          ops    = 0;
   logic [31:0] exp_sig  = '0;
   logic [31:0] exp_isig = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic der, input logic [31:0] x, input logic [31:0] res, input string nm);
      int n;
      @(negedge clk);
      if (der) begin isig_in = x; hw_sig = 2'b10; end
      else     begin sig_in  = x; hw_sig = 2'b01; end
      tick();
      check({nm, " busy"}, 32'(sw_sig), 32'd1);
      n = 0;
      while (sw_sig != 2'b10 && n < 10) begin
         tick();
         n++;
      end
      check({nm, " latency"}, 32'(n), der ? 32'd4 : 32'd3);
      if (der) exp_isig = res; else exp_sig = res;
      ops++;
      check({nm, " sig_out"}, sig_out, exp_sig);
      check({nm, " isig_out"}, isig_out, exp_isig);
      tick();
      check({nm, " done hold"}, 32'(sw_sig), 32'd2);
      @(negedge clk);
      hw_sig = 2'b00;
      tick();
      check({nm, " release"}, 32'(sw_sig), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_8000};
      vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0000_C000};
      vecs[2]  = '{1'b0, 32'hFFFF_0000, 32'h0000_4000};
      vecs[3]  = '{1'b0, 32'h0008_0000, 32'h0001_0000};
      vecs[4]  = '{1'b0, 32'h0002_6000, 32'h0000_EB00};
      vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0000};
      vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_4000};
      vecs[7]  = '{1'b1, 32'h0001_0000, 32'h0000_3000};
      vecs[8]  = '{1'b0, 32'h0005_0000, 32'h0001_0000};
      vecs[9]  = '{1'b0, 32'h0004_FFFF, 32'h0000_FFFF};
      vecs[10] = '{1'b0, 32'h0000_FFFF, 32'h0000_BFFF};
      vecs[11] = '{1'b0, 32'h0002_5FFF, 32'h0000_EBFF};
      vecs[12] = '{1'b1, 32'hFFFF_0000, 32'h0000_3000};
      vecs[13] = '{1'b1, 32'h0008_0000, 32'h0000_0000};
      vecs[14] = '{1'b0, 32'hFFFB_0000, 32'h0000_0000};

      rst_n = 1'b0; hw_sig = 2'b00; sig_in = '0; isig_in = '0;
      #12;
      check("reset sig_out", sig_out, 32'h0);
      check("reset isig_out", isig_out, 32'h0);
      check("reset sw_sig", 32'(sw_sig), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle after reset", 32'(sw_sig), 32'd0);

      for (int i = 0; i < 15; i++)
         run_op(vecs[i].der, vecs[i].x, vecs[i].res, $sformatf("vec%0d", i));

      // Command dropped and changed while busy: latched sigmoid still completes, done lasts one cycle.
      @(negedge clk);
      sig_in = 32'hFFFF_0000; hw_sig = 2'b01;
      tick();
      check("drop busy k", 32'(sw_sig), 32'd1);
      @(negedge clk);
      hw_sig = 2'b10; isig_in = 32'h0001_0000;
      tick();
      check("drop busy k1", 32'(sw_sig), 32'd1);
      @(negedge clk);
      hw_sig = 2'b00;
      tick();
      check("drop busy k2", 32'(sw_sig), 32'd1);
      tick();
      exp_sig = 32'h0000_4000;
      ops++;
      check("drop done k3", 32'(sw_sig), 32'd2);
      check("drop sig_out", sig_out, exp_sig);
      check("drop isig_out", isig_out, exp_isig);
      tick();
      check("drop idle k4", 32'(sw_sig), 32'd0);

      // Illegal command: error status held until 00, no command accepted meanwhile.
      @(negedge clk);
      hw_sig = 2'b11;
      tick();
      check("err enter", 32'(sw_sig), 32'd3);
      @(negedge clk);
      hw_sig = 2'b01; sig_in = 32'h0001_0000;
      tick();
      tick();
      check("err hold", 32'(sw_sig), 32'd3);
      check("err sig_out", sig_out, exp_sig);
      check("err isig_out", isig_out, exp_isig);
      @(negedge clk);
      hw_sig = 2'b00;
      tick();
      check("err release", 32'(sw_sig), 32'd0);
      tick();
      check("err stays idle", 32'(sw_sig), 32'd0);

      // Reset in the middle of an operation.
      @(negedge clk);
      sig_in = 32'h0001_0000; hw_sig = 2'b01;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      exp_sig = '0; exp_isig = '0; ops = 0;
      check("midrst sig_out", sig_out, exp_sig);
      check("midrst isig_out", isig_out, exp_isig);
      check("midrst sw_sig", 32'(sw_sig), 32'd0);
      @(negedge clk);
      hw_sig = 2'b00; rst_n = 1'b1;
      tick();
      tick();
      check("midrst no partial", sig_out, exp_sig);
      check("midrst idle", 32'(sw_sig), 32'd0);
      run_op(1'b0, 32'h0001_0000, 32'h0000_C000, "after reset");

`ifdef NEURAL_SIG_PERF_EN
      run_op(1'b1, 32'h0000_0000, 32'h0000_4000, "perf der");
      check("op_count", 32'(op_count), 32'(ops[15:0]));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past time limit");
      $fatal(1, "timeout");
   end

endmodule
